// File: rtl/uart_tx_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package uart_tx_mmio_pkg;

    // Word offsets within the 16-byte window, decoded from A[3:2].
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_RSVD    = 2'd3;

    // STATUS bit positions.
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    // 100 MHz / 115200 baud.
    localparam int DEFAULT_BAUD_DIV = 868;

    typedef enum logic [1:0] {
        SER_IDLE  = 2'd0,
        SER_START = 2'd1,
        SER_DATA  = 2'd2,
        SER_STOP  = 2'd3
    } ser_state_t;

    // A divider of zero would never let the baud counter expire sensibly;
    // it behaves as one clock per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serialiser: start bit, 8 data bits LSB first, stop bit, DIV clocks each.
// Latency: tx falls on the edge that accepts start; frame is 10*DIV cycles.
// Backpressure: start is taken only when idle or in the last STOP cycle (done).
// Ports: clk, rst_n (sync, active-low); start/data/div request a frame;
//        busy = not idle, done = last cycle of STOP, tx = serial line.
module uart_tx_serializer
    import uart_tx_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  data,
    input  logic [15:0] div,
    output logic        busy,
    output logic        done,
    output logic        tx
);

    ser_state_t  state, state_nxt;
    logic [15:0] baud_cnt, baud_cnt_nxt;
    logic [15:0] div_lat, div_lat_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        bit_end;

    assign bit_end = (baud_cnt == 16'd0);
    assign busy    = (state != SER_IDLE);
    assign done    = (state == SER_STOP) && bit_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= SER_IDLE;
            baud_cnt <= '0;
            div_lat  <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_cnt_nxt;
            div_lat  <= div_lat_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        div_lat_nxt  = div_lat;
        bit_cnt_nxt  = bit_cnt;
        shreg_nxt    = shreg;
        tx           = 1'b1;

        case (state)
            SER_IDLE: begin
                if (start) begin
                    state_nxt    = SER_START;
                    shreg_nxt    = data;
                    div_lat_nxt  = eff_div(div);
                    baud_cnt_nxt = eff_div(div) - 16'd1;
                    bit_cnt_nxt  = '0;
                end
            end
            SER_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_nxt    = SER_DATA;
                    baud_cnt_nxt = div_lat - 16'd1;
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
            SER_DATA: begin
                tx = shreg[0];
                if (bit_end) begin
                    shreg_nxt    = {1'b0, shreg[7:1]};
                    bit_cnt_nxt  = bit_cnt + 3'd1;
                    baud_cnt_nxt = div_lat - 16'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = SER_STOP;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
            SER_STOP: begin
                if (bit_end) begin
                    // Chain straight into the next start bit when a byte is
                    // waiting, so back-to-back frames have no idle gap.
                    if (start) begin
                        state_nxt    = SER_START;
                        shreg_nxt    = data;
                        div_lat_nxt  = eff_div(div);
                        baud_cnt_nxt = eff_div(div) - 16'd1;
                        bit_cnt_nxt  = '0;
                    end else begin
                        state_nxt = SER_IDLE;
                    end
                end else begin
                    baud_cnt_nxt = baud_cnt - 16'd1;
                end
            end
            default: begin
                state_nxt = SER_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART TX: register file, TX FIFO and 8N1 serialiser.
// Latency: RD registered (1 cycle); push at edge N starts the frame at N+1 if idle.
// Backpressure: none on the bus; pushes into a full FIFO are dropped and flag overflow.
// Ports: clk, rst_n (sync, active-low); sel/A/WD/WE bus in, RD registered out;
//        tx serial line (idle high); tx_empty = FIFO empty and serialiser idle.
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = DEFAULT_BAUD_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [11:0] A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        tx,
    output logic        tx_empty
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty;
    logic          overflow;
    logic [15:0]   baud_div;

    logic          wr_en;
    logic [1:0]    reg_off;
    logic          push_req, push_acc, pop;
    logic          ser_busy, ser_done;
    logic [31:0]   status;
    logic          unused_ok;

    assign reg_off  = A[3:2];
    assign wr_en    = sel & WE;
    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));

    // The serialiser accepts a byte when idle or on its final STOP cycle.
    assign pop      = !empty && (!ser_busy || ser_done);
    assign push_req = wr_en && (reg_off == REG_TXDATA);
    // Fullness is judged after a same-cycle pop frees a slot.
    assign push_acc = push_req && (!full || pop);

    assign tx_empty = empty && !ser_busy;

    assign unused_ok = ^{A[11:4], A[1:0], WD[31:16]};

    always_comb begin
        status                            = '0;
        status[ST_BUSY]                   = ser_busy;
        status[ST_FULL]                   = full;
        status[ST_EMPTY]                  = empty;
        status[ST_OVF]                    = overflow;
        status[ST_CNT_LSB+2:ST_CNT_LSB]   = 3'(count);
    end

    // FIFO storage carries no reset; occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            fifo_mem[wr_ptr] <= WD[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud_div <= 16'(DEFAULT_DIV);
            RD       <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_acc, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (push_req && !push_acc) begin
                overflow <= 1'b1;
            end else if (wr_en && (reg_off == REG_STATUS) && WD[ST_OVF]) begin
                overflow <= 1'b0;
            end

            if (wr_en && (reg_off == REG_BAUDDIV)) begin
                baud_div <= WD[15:0];
            end

            if (sel) begin
                case (reg_off)
                    REG_STATUS:  RD <= status;
                    REG_BAUDDIV: RD <= {16'd0, baud_div};
                    default:     RD <= '0;
                endcase
            end else begin
                RD <= '0;
            end
        end
    end

    uart_tx_serializer u_ser (
        .clk   (clk),
        .rst_n (rst_n),
        .start (pop),
        .data  (fifo_mem[rd_ptr]),
        .div   (baud_div),
        .busy  (ser_busy),
        .done  (ser_done),
        .tx    (tx)
    );

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sel;
    logic [11:0] A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        tx;
    logic        tx_empty;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam logic [11:0] AD_TXDATA  = 12'h000;
    localparam logic [11:0] AD_STATUS  = 12'h004;
    localparam logic [11:0] AD_BAUDDIV = 12'h008;
    localparam logic [11:0] AD_RSVD    = 12'h00C;

    uart_tx_mmio #(.FIFO_DEPTH(4), .DEFAULT_DIV(868)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (sel),
        .A        (A),
        .WD       (WD),
        .WE       (WE),
        .RD       (RD),
        .tx       (tx),
        .tx_empty (tx_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic        we;
        logic [11:0] a;
        logic [31:0] wd;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [14];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; WE = 1'b1; A = a; WD = d;
        @(posedge clk); #1;
        sel = 1'b0; WE = 1'b0;
    endtask

    task automatic bus_read(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; WE = 1'b0; A = a; WD = '0;
        @(posedge clk); #1;
        d = RD;
        sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called #1 after the edge where the start bit should begin; consumes
    // exactly 10*div cycles and checks every one against the 8N1 waveform.
    task automatic expect_frame(input logic [7:0] b, input int div, input string name);
        int bad;
        logic [7:0] cap;
        logic e;
        bad = 0;
        cap = '0;
        for (int k = 0; k < 10 * div; k++) begin
            int slot;
            slot = k / div;
            if (slot == 0)      e = 1'b0;
            else if (slot == 9) e = 1'b1;
            else                e = b[slot-1];
            if (tx !== e) bad++;
            if (slot >= 1 && slot <= 8 && (k % div) == 0) cap[slot-1] = tx;
            @(posedge clk); #1;
        end
        check({name, " bad cycles"}, 32'(bad), 32'd0);
        check({name, " byte"}, {24'd0, cap}, {24'd0, b});
    endtask

    initial begin
        logic [31:0] r;
        int lows;

        sel = 1'b0; WE = 1'b0; A = '0; WD = '0; rst_n = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset tx", {31'd0, tx}, 32'd1);
        check("reset RD", RD, 32'd0);
        check("reset tx_empty", {31'd0, tx_empty}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Register access table
        vt[0]  = '{1'b1, 1'b0, AD_STATUS,  32'h0,        1'b1, 32'h4};
        vt[1]  = '{1'b1, 1'b0, AD_BAUDDIV, 32'h0,        1'b1, 32'd868};
        vt[2]  = '{1'b1, 1'b0, AD_TXDATA,  32'h0,        1'b1, 32'h0};
        vt[3]  = '{1'b1, 1'b0, AD_RSVD,    32'h0,        1'b1, 32'h0};
        vt[4]  = '{1'b1, 1'b1, AD_BAUDDIV, 32'hABCD1234, 1'b0, 32'h0};
        vt[5]  = '{1'b1, 1'b0, 12'h7F8,    32'h0,        1'b1, 32'h1234};
        vt[6]  = '{1'b0, 1'b1, AD_BAUDDIV, 32'h55,       1'b0, 32'h0};
        vt[7]  = '{1'b1, 1'b0, AD_BAUDDIV, 32'h0,        1'b1, 32'h1234};
        vt[8]  = '{1'b0, 1'b0, AD_BAUDDIV, 32'h0,        1'b1, 32'h0};
        vt[9]  = '{1'b1, 1'b1, AD_RSVD,    32'hFFFFFFFF, 1'b0, 32'h0};
        vt[10] = '{1'b1, 1'b0, AD_RSVD,    32'h0,        1'b1, 32'h0};
        vt[11] = '{1'b1, 1'b1, AD_STATUS,  32'hFFFFFFF7, 1'b0, 32'h0};
        vt[12] = '{1'b1, 1'b0, AD_STATUS,  32'h0,        1'b1, 32'h4};
        vt[13] = '{1'b1, 1'b1, AD_BAUDDIV, 32'h0,        1'b0, 32'h0};

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            sel = vt[i].sel; WE = vt[i].we; A = vt[i].a; WD = vt[i].wd;
            @(posedge clk); #1;
            if (vt[i].chk) check($sformatf("vec%0d", i), RD, vt[i].exp);
            sel = 1'b0; WE = 1'b0;
        end

        // BAUDDIV=0 behaves as one clock per bit
        bus_read(AD_BAUDDIV, r);
        check("bauddiv zero readback", r, 32'h0);
        bus_write(AD_TXDATA, 32'h96);
        idle(1);
        expect_frame(8'h96, 1, "div0 frame");
        check("div0 tx_empty", {31'd0, tx_empty}, 32'd1);

        // Single byte, DIV=4
        bus_write(AD_BAUDDIV, 32'd4);
        bus_write(AD_TXDATA, 32'h55);
        check("single tx before start", {31'd0, tx}, 32'd1);
        idle(1);
        check("single tx_empty busy", {31'd0, tx_empty}, 32'd0);
        expect_frame(8'h55, 4, "single");
        check("single tx_empty after", {31'd0, tx_empty}, 32'd1);
        check("single tx idle", {31'd0, tx}, 32'd1);

        // Back-to-back, DIV=2
        bus_write(AD_BAUDDIV, 32'd2);
        bus_write(AD_TXDATA, 32'hA5);
        bus_write(AD_TXDATA, 32'h3C);
        expect_frame(8'hA5, 2, "b2b first");
        expect_frame(8'h3C, 2, "b2b second");
        check("b2b tx_empty", {31'd0, tx_empty}, 32'd1);

        // Push into a full FIFO on the cycle a pop frees a slot: accepted
        bus_write(AD_BAUDDIV, 32'd1);
        for (int i = 0; i < 5; i++) bus_write(AD_TXDATA, 32'h10 + 32'(i));
        idle(6);
        bus_write(AD_TXDATA, 32'hEE);
        bus_read(AD_STATUS, r);
        check("full+pop status", r, 32'h43);
        idle(70);
        check("full+pop drained tx_empty", {31'd0, tx_empty}, 32'd1);
        bus_read(AD_STATUS, r);
        check("full+pop drained status", r, 32'h04);

        // Overflow, DIV=100
        bus_write(AD_BAUDDIV, 32'd100);
        for (int i = 0; i < 6; i++) bus_write(AD_TXDATA, 32'h60 + 32'(i));
        bus_read(AD_STATUS, r);
        check("overflow status", r, 32'h4B);
        bus_write(AD_STATUS, 32'h8);
        bus_read(AD_STATUS, r);
        check("overflow cleared status", r, 32'h43);
        do_reset();

        // Mid-frame BAUDDIV change
        bus_write(AD_BAUDDIV, 32'd4);
        bus_write(AD_TXDATA, 32'h0F);
        bus_write(AD_TXDATA, 32'hF0);
        fork
            expect_frame(8'h0F, 4, "middiv first");
            begin
                idle(12);
                bus_write(AD_BAUDDIV, 32'd8);
            end
        join
        expect_frame(8'hF0, 8, "middiv second");
        check("middiv tx_empty", {31'd0, tx_empty}, 32'd1);

        // Reset mid-frame with two bytes queued
        bus_write(AD_BAUDDIV, 32'd4);
        bus_write(AD_TXDATA, 32'h11);
        bus_write(AD_TXDATA, 32'h22);
        bus_write(AD_TXDATA, 32'h33);
        idle(10);
        check("pre-reset in data", {31'd0, tx_empty}, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset tx", {31'd0, tx}, 32'd1);
        check("midreset tx_empty", {31'd0, tx_empty}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read(AD_STATUS, r);
        check("midreset status", r, 32'h04);
        bus_read(AD_BAUDDIV, r);
        check("midreset bauddiv", r, 32'd868);
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1) lows++;
            @(posedge clk); #1;
        end
        check("midreset no frames", 32'(lows), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
